// File: rtl/m92_int_sources.sv
// Interrupt source generator: vblank, raster compare, sprite-DMA complete and
// sound reply events, stretched to PULSE_LEN ce cycles on the intp lines.
module m92_int_sources #(
  parameter logic [8:0]  VBL_LINE   = 9'd248,
  parameter logic [9:0]  HINT_POS   = 10'd0,
  parameter int unsigned PULSE_LEN  = 4,
  parameter logic [15:0] DMA_CYCLES = 16'd1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [8:0] vcount,
  input  logic [9:0] hcount,
  input  logic       cs,
  input  logic       wr,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       dma_start,
  output logic       dma_busy,
  input  logic       snd_reply_wr,
  input  logic       snd_reply_rd,
  output logic [7:0] intp,
  output logic       dma_state_o
);

  localparam int CW = $clog2(PULSE_LEN + 1);

  typedef enum logic {
    DMA_IDLE = 1'b0,
    DMA_RUN  = 1'b1
  } dma_state_t;

  dma_state_t    state_q, state_d;
  logic [15:0]   dcnt_q, dcnt_d;
  logic [8:0]    line_q, line_d;
  logic          en_q, en_d;
  logic          snd_q, snd_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    pulse_q, pulse_d;

  logic       hit_pos;
  logic       vbl_trig;
  logic       ras_trig;
  logic       dma_trig;
  logic [2:0] trig;

  // Line events compare against the raster register as it stood before any
  // write in this same ce cycle.
  assign hit_pos  = (hcount == HINT_POS);
  assign vbl_trig = hit_pos && (vcount == VBL_LINE);
  assign ras_trig = hit_pos && en_q && (vcount == line_q);
  assign trig     = {ras_trig, dma_trig, vbl_trig};

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    dma_trig = 1'b0;
    case (state_q)
      DMA_IDLE: begin
        if (dma_start) begin
          dcnt_d  = DMA_CYCLES - 16'd1;
          state_d = DMA_RUN;
        end
      end
      DMA_RUN: begin
        if (dcnt_q == 16'd0) begin
          dma_trig = 1'b1;
          state_d  = DMA_IDLE;
        end else begin
          dcnt_d = dcnt_q - 16'd1;
        end
      end
      default: state_d = DMA_IDLE;
    endcase
  end

  // The pulse bit is registered alongside its counter, so it is high exactly
  // when the next counter value is nonzero; a retrigger leaves no low gap.
  always_comb begin
    pulse_d = 3'b000;
    for (int n = 0; n < 3; n++) begin
      cnt_d[n] = cnt_q[n];
      if (trig[n]) begin
        cnt_d[n] = CW'(PULSE_LEN);
      end else if (cnt_q[n] != '0) begin
        cnt_d[n] = cnt_q[n] - CW'(1);
      end
      pulse_d[n] = trig[n] || (cnt_q[n] > CW'(1));
    end
  end

  always_comb begin
    line_d = line_q;
    en_d   = en_q;
    if (cs && wr) begin
      if (!a0) begin
        line_d[7:0] = din;
      end else begin
        line_d[8] = din[0];
        en_d      = din[7];
      end
    end
    snd_d = snd_q;
    if (snd_reply_wr) begin
      snd_d = 1'b1;
    end else if (snd_reply_rd) begin
      snd_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DMA_IDLE;
      dcnt_q  <= 16'd0;
      line_q  <= 9'd0;
      en_q    <= 1'b0;
      snd_q   <= 1'b0;
      pulse_q <= 3'b000;
      for (int n = 0; n < 3; n++) begin
        cnt_q[n] <= '0;
      end
    end else if (ce) begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      line_q  <= line_d;
      en_q    <= en_d;
      snd_q   <= snd_d;
      pulse_q <= pulse_d;
      for (int n = 0; n < 3; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign dma_busy    = (state_q == DMA_RUN);
  assign dma_state_o = state_q;
  assign intp        = {4'b0000, snd_q, pulse_q};

endmodule

// File: tb/tb_m92_int_sources.sv
// Bench for m92_int_sources: directed checks of each interrupt source plus a
// randomized run compared every cycle against an event-time reference model.
module tb_m92_int_sources;

  localparam int PL = 4;
  localparam int DC = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic [8:0] vcount = 9'd0;
  logic [9:0] hcount = 10'd5;
  logic       cs = 1'b0;
  logic       wr = 1'b0;
  logic       a0 = 1'b0;
  logic [7:0] din = 8'd0;
  logic       dma_start = 1'b0;
  logic       dma_busy;
  logic       snd_reply_wr = 1'b0;
  logic       snd_reply_rd = 1'b0;
  logic [7:0] intp;
  logic       dma_state_o;

  m92_int_sources #(
    .VBL_LINE  (9'd248),
    .HINT_POS  (10'd0),
    .PULSE_LEN (PL),
    .DMA_CYCLES(16'(DC))
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .vcount      (vcount),
    .hcount      (hcount),
    .cs          (cs),
    .wr          (wr),
    .a0          (a0),
    .din         (din),
    .dma_start   (dma_start),
    .dma_busy    (dma_busy),
    .snd_reply_wr(snd_reply_wr),
    .snd_reply_rd(snd_reply_rd),
    .intp        (intp),
    .dma_state_o (dma_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: remembers the ce-cycle index of the latest trigger per
  // source and the start index of the running DMA.
  longint     cyc;
  longint     last0, last1, last2, dma_s;
  logic [8:0] m_line;
  logic       m_en;
  logic       m_pend;
  logic [7:0] exp_intp = 8'd0;
  logic       exp_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_clear();
    cyc    = 0;
    last0  = -100000;
    last1  = -100000;
    last2  = -100000;
    dma_s  = -100000;
    m_line = 9'd0;
    m_en   = 1'b0;
    m_pend = 1'b0;
    exp_intp = 8'd0;
    exp_busy = 1'b0;
  endtask

  task automatic model_step();
    logic busy_now;
    if (ce) begin
      cyc++;
      if (vcount == 9'd248 && hcount == 10'd0) last0 = cyc;
      if (m_en && vcount == m_line && hcount == 10'd0) last2 = cyc;
      if (cs && wr) begin
        if (!a0) m_line[7:0] = din;
        else begin
          m_line[8] = din[0];
          m_en      = din[7];
        end
      end
      busy_now = (cyc >= dma_s + 1) && (cyc <= dma_s + DC);
      if (cyc == dma_s + DC) last1 = cyc;
      if (dma_start && !busy_now) dma_s = cyc;
      if (snd_reply_wr) m_pend = 1'b1;
      else if (snd_reply_rd) m_pend = 1'b0;
    end
    exp_intp = {4'b0000, m_pend, (cyc - last2 < PL), (cyc - last1 < PL), (cyc - last0 < PL)};
    exp_busy = (cyc >= dma_s) && (cyc < dma_s + DC);
  endtask

  // scoreboard compare, every cycle just after the active edge
  always @(posedge clk) begin
    #1;
    chk("intp", {24'd0, intp}, {24'd0, exp_intp});
    chk("dma_busy", {31'd0, dma_busy}, {31'd0, exp_busy});
  end

  // driver tasks
  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    ce = 1'b1; vcount = 9'd0; hcount = 10'd5;
    cs = 1'b0; wr = 1'b0; a0 = 1'b0; din = 8'd0;
    dma_start = 1'b0; snd_reply_wr = 1'b0; snd_reply_rd = 1'b0;
  endtask

  task automatic wr_reg(input logic sel, input logic [7:0] d);
    idle();
    cs = 1'b1; wr = 1'b1; a0 = sel; din = d;
    tick();
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    #1;
    chk("rst_async_intp", {24'd0, intp}, 32'd0);
    chk("rst_async_busy", {31'd0, dma_busy}, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    model_clear();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    chk("reset_intp", {24'd0, intp}, 32'd0);
    chk("reset_busy", {31'd0, dma_busy}, 32'd0);

    // vblank pulse of exactly PL cycles
    vcount = 9'd248; hcount = 10'd0;
    tick();
    idle();
    for (int i = 0; i < PL; i++) begin
      chk("vbl_pulse", {24'd0, intp}, 32'h01);
      tick();
    end
    chk("vbl_end", {24'd0, intp}, 32'h00);

    // strobe with ce=0 is ignored
    ce = 1'b0; vcount = 9'd248; hcount = 10'd0;
    tick();
    idle();
    tick();
    chk("ce_low_ignored", {24'd0, intp}, 32'h00);

    // raster line 0x120 enabled, then disabled
    wr_reg(1'b0, 8'h20);
    wr_reg(1'b1, 8'h81);
    vcount = 9'd288; hcount = 10'd0;
    tick();
    idle();
    chk("ras_on", {24'd0, intp}, 32'h04);
    repeat (PL) tick();
    chk("ras_end", {24'd0, intp}, 32'h00);
    wr_reg(1'b1, 8'h01);
    vcount = 9'd288; hcount = 10'd0;
    tick();
    idle();
    chk("ras_off", {24'd0, intp}, 32'h00);

    // raster on the vblank line: both bits together; write on match uses old value
    wr_reg(1'b0, 8'hF8);
    wr_reg(1'b1, 8'h80);
    vcount = 9'd248; hcount = 10'd0;
    tick();
    idle();
    chk("both_rise", {24'd0, intp}, 32'h05);
    repeat (PL + 1) tick();
    vcount = 9'd248; hcount = 10'd0; cs = 1'b1; wr = 1'b1; a0 = 1'b0; din = 8'h00;
    tick();
    idle();
    chk("old_value_match", {24'd0, intp}, 32'h05);
    repeat (PL + 1) tick();
    vcount = 9'd248; hcount = 10'd0;
    tick();
    idle();
    chk("new_value_used", {24'd0, intp}, 32'h01);
    wr_reg(1'b1, 8'h00);
    repeat (PL + 1) tick();

    // DMA: busy DC cycles, restart attempt ignored, one completion pulse
    dma_start = 1'b1;
    tick();
    idle();
    for (int i = 0; i < DC; i++) begin
      chk("dma_busy_run", {31'd0, dma_busy}, 32'd1);
      chk("dma_no_early", {24'd0, intp}, 32'h00);
      dma_start = (i == 5);
      tick();
      dma_start = 1'b0;
    end
    chk("dma_busy_done", {31'd0, dma_busy}, 32'd0);
    chk("dma_pulse", {24'd0, intp}, 32'h02);
    repeat (PL) tick();
    chk("dma_once", {24'd0, intp}, 32'h00);
    repeat (DC) tick();
    chk("dma_no_second", {24'd0, intp}, 32'h00);

    // reset mid-run: no completion pulse
    dma_start = 1'b1;
    tick();
    idle();
    repeat (5) tick();
    do_reset();
    repeat (DC + 4) tick();
    chk("dma_abort", {24'd0, intp}, 32'h00);

    // sound reply level
    snd_reply_wr = 1'b1;
    tick();
    idle();
    chk("snd_set", {24'd0, intp}, 32'h08);
    repeat (3) tick();
    chk("snd_hold", {24'd0, intp}, 32'h08);
    snd_reply_wr = 1'b1; snd_reply_rd = 1'b1;
    tick();
    idle();
    chk("snd_set_wins", {24'd0, intp}, 32'h08);
    snd_reply_rd = 1'b1;
    tick();
    idle();
    chk("snd_clear", {24'd0, intp}, 32'h00);

    // vblank retrigger two cycles into the pulse: 2+PL high cycles, no gap
    vcount = 9'd248; hcount = 10'd0;
    tick();
    idle();
    tick();
    vcount = 9'd248; hcount = 10'd0;
    tick();
    idle();
    for (int i = 3; i <= 7; i++) begin
      chk("retrig_shape", {31'd0, intp[0]}, {31'd0, (i <= 2 + PL)});
      tick();
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      ce = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2: vcount = 9'd248;
        3, 4, 5: vcount = m_line;
        default: vcount = 9'($urandom_range(0, 511));
      endcase
      hcount = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
      cs = ($urandom_range(0, 5) == 0);
      wr = 1'($urandom_range(0, 1));
      a0 = 1'($urandom_range(0, 1));
      din = 8'($urandom_range(0, 255));
      dma_start = ($urandom_range(0, 29) == 0);
      snd_reply_wr = ($urandom_range(0, 15) == 0);
      snd_reply_rd = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
